// File: rtl/rsa_pkg.sv
// ----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA job sequencer slice: the sequencer FSM state
// encoding, the encrypt/decrypt direction codes and the default prime width.
// No ports (package).
// ----------------------------------------------------------------------------
package rsa_pkg;

    localparam int unsigned DEFAULT_WIDTH = 128;

    // Direction codes as seen on job_enc_dec / core_encrypt_decrypt
    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INV_START = 3'd1,
        INV_ARM   = 3'd2,
        INV_WAIT  = 3'd3,
        EXP_START = 3'd4,
        EXP_ARM   = 3'd5,
        EXP_WAIT  = 3'd6,
        OUT       = 3'd7
    } state_e;

endpackage

// File: rtl/rsa_key_cache.sv
// ----------------------------------------------------------------------------
// rsa_key_cache
// Remembers p, q and direction of the last completed key inversion and
// reports whether an incoming job can reuse it.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   store                 - record store_* as the current inverted key
//   invalidate            - forget the cached key (abandoned job)
//   store_p/q/enc_dec     - key values that were just inverted by the core
//   cmp_p/q/enc_dec       - key values offered with the next job
//   hit                   - cached key valid and equal to cmp_* (combinational)
// ----------------------------------------------------------------------------
module rsa_key_cache
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             store,
    input  logic             invalidate,
    input  logic [WIDTH-1:0] store_p,
    input  logic [WIDTH-1:0] store_q,
    input  logic             store_enc_dec,
    input  logic [WIDTH-1:0] cmp_p,
    input  logic [WIDTH-1:0] cmp_q,
    input  logic             cmp_enc_dec,
    output logic             hit
);

    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             enc_dec_q, enc_dec_d;
    logic             key_valid_q, key_valid_d;

    // Next-state for the cached key; store wins over invalidate because both
    // cannot legally happen in the same cycle.
    always_comb begin
        p_d         = p_q;
        q_d         = q_q;
        enc_dec_d   = enc_dec_q;
        key_valid_d = key_valid_q;
        if (store) begin
            p_d         = store_p;
            q_d         = store_q;
            enc_dec_d   = store_enc_dec;
            key_valid_d = 1'b1;
        end else if (invalidate) begin
            key_valid_d = 1'b0;
        end else begin
            key_valid_d = key_valid_q;
        end
    end

    // Cached key registers
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q         <= '0;
            q_q         <= '0;
            enc_dec_q   <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            q_q         <= q_d;
            enc_dec_q   <= enc_dec_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign hit = key_valid_q && (p_q == cmp_p) && (q_q == cmp_q) && (enc_dec_q == cmp_enc_dec);

endmodule

// File: rtl/rsa_job_sequencer.sv
// ----------------------------------------------------------------------------
// rsa_job_sequencer
// Front-end for the RSA control core: accepts a job (p, q, direction, message)
// over valid/ready, pulses the core's inverter and mod-exp starts, waits for
// the finish flags and returns the result over valid/ready. Key inversion is
// skipped when p, q and direction match the last completed inversion.
// Optional watchdog: define RSA_JOB_SEQ_TIMEOUT_EN to abort a WAIT phase after
// TIMEOUT_CYCLES cycles and raise a sticky timeout_err.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   key_p, key_q, job_enc_dec, job_msg - job contents, sampled on accept
//   job_valid / job_ready              - job handshake
//   core_p, core_q, core_encrypt_decrypt, core_msg_in - held core operands
//   core_reset_inverter, core_reset_mod_exp           - one-cycle start pulses
//   core_inverter_finish, core_mod_exp_finish, core_msg_out - core status/result
//   res_msg / res_valid / res_ready    - result handshake
//   busy                               - sequencer not idle
//   timeout_err                        - sticky watchdog flag (0 when disabled)
// ----------------------------------------------------------------------------
module rsa_job_sequencer
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   key_p,
    input  logic [WIDTH-1:0]   key_q,
    input  logic               job_enc_dec,
    input  logic [2*WIDTH-1:0] job_msg,
    input  logic               job_valid,
    output logic               job_ready,
    output logic [WIDTH-1:0]   core_p,
    output logic [WIDTH-1:0]   core_q,
    output logic               core_encrypt_decrypt,
    output logic [2*WIDTH-1:0] core_msg_in,
    output logic               core_reset_inverter,
    output logic               core_reset_mod_exp,
    input  logic               core_inverter_finish,
    input  logic               core_mod_exp_finish,
    input  logic [2*WIDTH-1:0] core_msg_out,
    output logic [2*WIDTH-1:0] res_msg,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               busy,
    output logic               timeout_err
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   core_p_q, core_p_d;
    logic [WIDTH-1:0]   core_q_q, core_q_d;
    logic               core_enc_q, core_enc_d;
    logic [2*WIDTH-1:0] core_msg_q, core_msg_d;
    logic [2*WIDTH-1:0] res_msg_q, res_msg_d;
    logic               inv_pulse_q, inv_pulse_d;
    logic               exp_pulse_q, exp_pulse_d;
    logic               res_valid_q, res_valid_d;
    logic               job_ready_q, job_ready_d;
    logic               busy_q, busy_d;
    logic               cache_hit_s;
    logic               cache_store_s;
    logic               cache_inval_s;

`ifdef RSA_JOB_SEQ_TIMEOUT_EN
    localparam logic [31:0] PHASE_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]        phase_cnt_q, phase_cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic               phase_expired_s;
`endif

    rsa_key_cache #(
        .WIDTH (WIDTH)
    ) u_key_cache (
        .clk           (clk),
        .reset         (reset),
        .store         (cache_store_s),
        .invalidate    (cache_inval_s),
        .store_p       (core_p_q),
        .store_q       (core_q_q),
        .store_enc_dec (core_enc_q),
        .cmp_p         (key_p),
        .cmp_q         (key_q),
        .cmp_enc_dec   (job_enc_dec),
        .hit           (cache_hit_s)
    );

    // Next-state, operand latching and registered-output decode
    always_comb begin
        state_d       = state_q;
        core_p_d      = core_p_q;
        core_q_d      = core_q_q;
        core_enc_d    = core_enc_q;
        core_msg_d    = core_msg_q;
        res_msg_d     = res_msg_q;
        cache_store_s = 1'b0;
        cache_inval_s = 1'b0;
`ifdef RSA_JOB_SEQ_TIMEOUT_EN
        phase_cnt_d     = phase_cnt_q;
        timeout_err_d   = timeout_err_q;
        phase_expired_s = (phase_cnt_q == PHASE_LAST);
`endif
        case (state_q)
            IDLE: begin
                if (job_valid && job_ready_q) begin
                    core_p_d   = key_p;
                    core_q_d   = key_q;
                    core_enc_d = job_enc_dec;
                    core_msg_d = job_msg;
                    state_d    = cache_hit_s ? EXP_START : INV_START;
                end else begin
                    state_d = IDLE;
                end
            end
            INV_START: state_d = INV_ARM;
            INV_ARM: begin
                // Finish flag may still be high from the previous job here
                state_d = INV_WAIT;
`ifdef RSA_JOB_SEQ_TIMEOUT_EN
                phase_cnt_d = 32'd0;
`endif
            end
            INV_WAIT: begin
                if (core_inverter_finish) begin
                    cache_store_s = 1'b1;
                    state_d       = EXP_START;
                end
`ifdef RSA_JOB_SEQ_TIMEOUT_EN
                else if (phase_expired_s) begin
                    timeout_err_d = 1'b1;
                    cache_inval_s = 1'b1;
                    state_d       = IDLE;
                end else begin
                    phase_cnt_d = phase_cnt_q + 32'd1;
                end
`else
                else begin
                    state_d = INV_WAIT;
                end
`endif
            end
            EXP_START: state_d = EXP_ARM;
            EXP_ARM: begin
                state_d = EXP_WAIT;
`ifdef RSA_JOB_SEQ_TIMEOUT_EN
                phase_cnt_d = 32'd0;
`endif
            end
            EXP_WAIT: begin
                if (core_mod_exp_finish) begin
                    res_msg_d = core_msg_out;
                    state_d   = OUT;
                end
`ifdef RSA_JOB_SEQ_TIMEOUT_EN
                else if (phase_expired_s) begin
                    timeout_err_d = 1'b1;
                    cache_inval_s = 1'b1;
                    state_d       = IDLE;
                end else begin
                    phase_cnt_d = phase_cnt_q + 32'd1;
                end
`else
                else begin
                    state_d = EXP_WAIT;
                end
`endif
            end
            OUT: begin
                // No bypass: a new job is only taken once back in IDLE
                if (res_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are flop outputs
        job_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == OUT);
        inv_pulse_d = (state_d == INV_START);
        exp_pulse_d = (state_d == EXP_START);
    end

    // State, operand and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            core_p_q    <= '0;
            core_q_q    <= '0;
            core_enc_q  <= 1'b0;
            core_msg_q  <= '0;
            res_msg_q   <= '0;
            inv_pulse_q <= 1'b0;
            exp_pulse_q <= 1'b0;
            res_valid_q <= 1'b0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            core_p_q    <= core_p_d;
            core_q_q    <= core_q_d;
            core_enc_q  <= core_enc_d;
            core_msg_q  <= core_msg_d;
            res_msg_q   <= res_msg_d;
            inv_pulse_q <= inv_pulse_d;
            exp_pulse_q <= exp_pulse_d;
            res_valid_q <= res_valid_d;
            job_ready_q <= job_ready_d;
            busy_q      <= busy_d;
        end
    end

`ifdef RSA_JOB_SEQ_TIMEOUT_EN
    // Watchdog phase counter and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_cnt_q   <= 32'd0;
            timeout_err_q <= 1'b0;
        end else begin
            phase_cnt_q   <= phase_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign job_ready            = job_ready_q;
    assign busy                 = busy_q;
    assign res_valid            = res_valid_q;
    assign res_msg              = res_msg_q;
    assign core_p               = core_p_q;
    assign core_q               = core_q_q;
    assign core_encrypt_decrypt = core_enc_q;
    assign core_msg_in          = core_msg_q;
    assign core_reset_inverter  = inv_pulse_q;
    assign core_reset_mod_exp   = exp_pulse_q;

endmodule
